// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns, checks and issues one data-memory access at a time.
// Optional feature: define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES for mem_ack.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request (req_ready = 1)
// ACCESS | mem_req held high until mem_ack (or timeout when enabled)
// RESP   | one-cycle rsp_valid pulse carrying rsp_rdata / rsp_err
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The wait counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        legal_f3;
    logic        misalign;
    logic        fault;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  wait_cnt;
`endif

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        legal_f3   = 1'b0;
        misalign   = 1'b0;
        strb_next  = 4'b0000;
        wdata_next = req_wdata;

        if (req_we) begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end

        case (req_funct3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase

        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    strb_next  = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    strb_next  = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    strb_next  = 4'b1111;
                    wdata_next = req_wdata;
                end
            endcase
        end
    end

    assign fault = !legal_f3 || misalign;

    always_comb begin
        ld_byte   = mem_rdata[7:0];
        ld_result = 32'd0;

        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        // Stores complete with zero data.
        if (!mem_we) begin
            case (funct3_q)
                3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
                3'b010:  ld_result = mem_rdata;
                3'b100:  ld_result = {24'd0, ld_byte};
                3'b101:  ld_result = {16'd0, ld_half};
                default: ld_result = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt  <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (fault) begin
                            state     <= ST_RESP;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wstrb <= strb_next;
                            mem_wdata <= wdata_next;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt  <= 8'd0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        state     <= ST_RESP;
                        mem_req   <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ld_result;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        state     <= ST_RESP;
                        mem_req   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default build, timeout disabled).
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk;
    int n_pass;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        cyc();
        req_valid  = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;

        #2;
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        #10 rst_n = 1'b1;
        cyc();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // LB 0x1003, ack in the second ACCESS cycle
        issue(1'b0, 3'b000, 32'h0000_1003, 32'd0);
        chk("lb_mem_req",  32'(mem_req),   32'd1);
        chk("lb_mem_addr", mem_addr,       32'h0000_1000);
        chk("lb_wstrb",    32'(mem_wstrb), 32'd0);
        chk("lb_we",       32'(mem_we),    32'd0);
        chk("lb_busy",     32'(req_ready), 32'd0);
        cyc();
        chk("lb_mem_req2", 32'(mem_req),   32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_1234;
        cyc();
        mem_ack   = 1'b0;
        chk("lb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lb_rsp_rdata", rsp_rdata,      32'hFFFF_FF80);
        chk("lb_rsp_err",   32'(rsp_err),   32'd0);
        chk("lb_mem_req_off", 32'(mem_req), 32'd0);
        cyc();
        chk("lb_pulse_end", 32'(rsp_valid), 32'd0);
        chk("lb_ready",     32'(req_ready), 32'd1);
        chk("lb_hold",      rsp_rdata,      32'hFFFF_FF80);

        // SH 0x2002, ack immediately
        issue(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
        chk("sh_wstrb", 32'(mem_wstrb), 32'h0000_000C);
        chk("sh_wdata", mem_wdata,      32'hBEEF_BEEF);
        chk("sh_we",    32'(mem_we),    32'd1);
        chk("sh_addr",  mem_addr,       32'h0000_2000);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sh_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sh_rsp_rdata", rsp_rdata,      32'd0);
        chk("sh_rsp_err",   32'(rsp_err),   32'd0);
        cyc();

        // LW misaligned: no access, response next cycle
        issue(1'b0, 3'b010, 32'h0000_3001, 32'd0);
        chk("lw_mis_mem_req", 32'(mem_req),   32'd0);
        chk("lw_mis_valid",   32'(rsp_valid), 32'd1);
        chk("lw_mis_err",     32'(rsp_err),   32'd1);
        chk("lw_mis_rdata",   rsp_rdata,      32'd0);
        cyc();
        chk("lw_mis_pulse_end", 32'(rsp_valid), 32'd0);
        chk("lw_mis_err_hold",  32'(rsp_err),   32'd1);

        // LHU 0x4002, ack in sixth ACCESS cycle; a new request while busy is ignored
        issue(1'b0, 3'b101, 32'h0000_4002, 32'd0);
        req_valid = 1'b1;
        req_addr  = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) begin
            chk("lhu_mem_req_hi", 32'(mem_req), 32'd1);
            chk("lhu_addr_stable", mem_addr,   32'h0000_4000);
            if (i == 5) begin
                req_valid = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = 32'h9ABC_0000;
            end
            cyc();
        end
        mem_ack = 1'b0;
        chk("lhu_mem_req_off", 32'(mem_req),   32'd0);
        chk("lhu_rsp_valid",   32'(rsp_valid), 32'd1);
        chk("lhu_rsp_rdata",   rsp_rdata,      32'h0000_9ABC);
        chk("lhu_rsp_err",     32'(rsp_err),   32'd0);
        cyc();

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("stray_ack_valid", 32'(rsp_valid), 32'd0);
        chk("stray_ack_req",   32'(mem_req),   32'd0);
        chk("stray_ack_ready", 32'(req_ready), 32'd1);

        // SB 0x5001
        issue(1'b1, 3'b000, 32'h0000_5001, 32'h1234_56A5);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h0000_0002);
        chk("sb_wdata", mem_wdata,      32'hA5A5_A5A5);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sb_rsp_valid", 32'(rsp_valid), 32'd1);
        cyc();

        // LH 0x6002 sign-extends the upper half
        issue(1'b0, 3'b001, 32'h0000_6002, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8001_7777;
        cyc();
        mem_ack = 1'b0;
        chk("lh_rsp_rdata", rsp_rdata, 32'hFFFF_8001);
        cyc();

        // LBU 0x7001 zero-extends byte 1
        issue(1'b0, 3'b100, 32'h0000_7001, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_F000;
        cyc();
        mem_ack = 1'b0;
        chk("lbu_rsp_rdata", rsp_rdata, 32'h0000_00F0);
        cyc();

        // Illegal funct3 for a store, and for a load; misaligned LH
        issue(1'b1, 3'b100, 32'h0000_7000, 32'd0);
        chk("st_ill_req", 32'(mem_req), 32'd0);
        chk("st_ill_err", 32'(rsp_err), 32'd1);
        cyc();
        issue(1'b0, 3'b011, 32'h0000_7000, 32'd0);
        chk("ld_ill_err",   32'(rsp_err),   32'd1);
        chk("ld_ill_valid", 32'(rsp_valid), 32'd1);
        cyc();
        issue(1'b0, 3'b001, 32'h0000_6001, 32'd0);
        chk("lh_mis_req", 32'(mem_req), 32'd0);
        chk("lh_mis_err", 32'(rsp_err), 32'd1);
        cyc();

        // SW then reset asserted mid-ACCESS
        issue(1'b1, 3'b010, 32'h0000_8000, 32'h1111_2222);
        chk("sw_mem_req", 32'(mem_req),   32'd1);
        chk("sw_wstrb",   32'(mem_wstrb), 32'h0000_000F);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_mem_req",   32'(mem_req),   32'd0);
        chk("arst_mem_we",    32'(mem_we),    32'd0);
        chk("arst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("arst_rsp_err",   32'(rsp_err),   32'd0);
        chk("arst_rsp_rdata", rsp_rdata,      32'd0);
        cyc();
        chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("arst_ready",     32'(req_ready), 32'd1);
        chk("arst_no_rsp2",   32'(rsp_valid), 32'd0);
        chk("arst_mem_req2",  32'(mem_req),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for mem_ack; it is used only under LSU_TIMEOUT_EN.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  execute stage presents a memory operation.
REQ-005 The block SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 The block SHALL have port req_addr  input  32  effective address, i.e. the ALU ADD result.
REQ-009 The block SHALL have port req_wdata  input  32  store data (rs2).
REQ-010 The block SHALL have port mem_req  output  1  data-memory request.
REQ-011 The block SHALL have port mem_we  output  1  data-memory write enable.
REQ-012 The block SHALL have port mem_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}.
REQ-013 The block SHALL have port mem_wstrb  output  4  byte-lane write strobes.
REQ-014 The block SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-015 The block SHALL have port mem_ack  input  1  memory completes the access this cycle.
REQ-016 The block SHALL have port mem_rdata  input  32  read word, valid with mem_ack.
REQ-017 The block SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-018 The block SHALL have port rsp_rdata  output  32  extended load result; 0 for stores.
REQ-019 The block SHALL have port rsp_err  output  1  access faulted (misaligned, illegal funct3, timeout).

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid & req_ready, the block SHALL latch all req_* inputs and go to ACCESS (legal) or RESP with rsp_err=1 (fault), with no memory access on a fault.
REQ-022 Legal funct3 values SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other value SHALL be illegal.
REQ-023 A half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be misaligned.
REQ-024 mem_req SHALL be registered, high throughout ACCESS, and low in every other state; mem_we, mem_addr, mem_wstrb and mem_wdata SHALL be stable while mem_req is high.
REQ-025 mem_wstrb SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; 4'b0000 for loads.
REQ-026 mem_wdata SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-027 On mem_ack in ACCESS, the block SHALL select the addressed byte or half of mem_rdata, sign-extend it (LB, LH) or zero-extend it (LBU, LHU), register it into rsp_rdata, and go to RESP.
REQ-028 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; accept-to-rsp_valid latency SHALL be 2 cycles plus memory wait cycles, and 1 cycle for faults.
REQ-029 mem_ack outside ACCESS SHALL be ignored; req_valid while req_ready=0 SHALL be ignored, and upstream SHALL hold its request.
REQ-030 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-031 Asserting rst_n low SHALL immediately force IDLE, mem_req=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wstrb=0 and mem_we=0, including mid-ACCESS; an abandoned access SHALL produce no response.
REQ-032 req_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Configuration
REQ-033 With LSU_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack; on reaching TIMEOUT_CYCLES, the block SHALL drop mem_req and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-034 Without LSU_TIMEOUT_EN, the counter logic SHALL be absent, and ACCESS SHALL wait for mem_ack indefinitely.

Verification
REQ-035 LB, addr 0x1003, mem_rdata 0x80FF_1234, ack after 1 cycle -> mem_addr 0x1000, rsp_rdata 0xFFFF_FF80, rsp_err 0.
REQ-036 SH, addr 0x2002, wdata 0xDEAD_BEEF -> mem_wstrb 4'b1100, mem_wdata 0xBEEF_BEEF, rsp_valid 1 cycle after ack.
REQ-037 LW, addr 0x3001 -> no mem_req, rsp_valid the next cycle, rsp_err 1.
REQ-038 LHU, addr 0x4002, mem_rdata 0x9ABC_0000, ack delayed 5 cycles -> mem_req high 6 cycles, rsp_rdata 0x0000_9ABC.
REQ-039 Assert rst_n low during ACCESS -> mem_req falls asynchronously, no rsp_valid, req_ready 1 after release.
REQ-040 LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 cycles, rsp_err 1.
